// File: rtl/sha256_msg_padder.sv
// sha256_msg_padder: FIPS 180-4 padding front-end for the SHA-256 core.
// Packs 32-bit message words into 512-bit blocks with 0x80, zero fill and length.
module sha256_msg_padder #(
  parameter int LEN_W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  in_data,
  input  logic         in_valid,
  input  logic         in_last,
  input  logic [2:0]   in_bytes,
  output logic         in_ready,
  output logic [511:0] blk_data,
  output logic         blk_valid,
  output logic         blk_first,
  output logic         blk_last,
  input  logic         blk_ready
);

  typedef enum logic [1:0] {FILL, PAD, EMIT} state_t;

  state_t           st_q;
  logic [4:0]       idx_q;
  logic [LEN_W-1:0] len_q;
  logic             pad_done_q;
  logic             padding_q;
  logic             spill_q;
  logic             in_ready_q;
  logic             blk_valid_q;
  logic             blk_first_q;
  logic             blk_last_q;
  logic [31:0]      buf_q [16];

  logic [2:0]  k;
  logic [31:0] tail_w;
  logic [63:0] len64;
  logic [3:0]  wi;
  logic        acc;

  assign k     = (in_bytes > 3'd4) ? 3'd4 : in_bytes;
  assign len64 = 64'(len_q);
  assign wi    = idx_q[3:0];
  assign acc   = in_valid & in_ready_q;

  always_comb begin
    tail_w = '0;
    for (int b = 0; b < 4; b++) begin
      if (3'(b) < k)
        tail_w[31-8*b -: 8] = in_data[31-8*b -: 8];
      else if (3'(b) == k)
        tail_w[31-8*b -: 8] = 8'h80;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q        <= FILL;
      idx_q       <= '0;
      len_q       <= '0;
      pad_done_q  <= 1'b0;
      padding_q   <= 1'b0;
      spill_q     <= 1'b0;
      in_ready_q  <= 1'b0;
      blk_valid_q <= 1'b0;
      blk_first_q <= 1'b1;
      blk_last_q  <= 1'b0;
      for (int i = 0; i < 16; i++)
        buf_q[i] <= '0;
    end else begin
      unique case (st_q)
        FILL: begin
          in_ready_q <= 1'b1;
          if (acc) begin
            idx_q <= idx_q + 5'd1;
            if (!in_last) begin
              buf_q[wi] <= in_data;
              len_q     <= len_q + LEN_W'(32);
            end else begin
              buf_q[wi]  <= tail_w;
              len_q      <= len_q + LEN_W'({k, 3'b000});
              pad_done_q <= (k != 3'd4);
              padding_q  <= 1'b1;
              spill_q    <= (k != 3'd4) && (idx_q >= 5'd14);
              st_q       <= PAD;
              in_ready_q <= 1'b0;
            end
            if (idx_q == 5'd15) begin
              st_q        <= EMIT;
              in_ready_q  <= 1'b0;
              blk_valid_q <= 1'b1;
              blk_last_q  <= 1'b0;
            end
          end
        end
        PAD: begin
          if (idx_q == 5'd16) begin
            st_q        <= EMIT;
            blk_valid_q <= 1'b1;
            blk_last_q  <= 1'b0;
          end else begin
            idx_q <= idx_q + 5'd1;
            // spill: marker sits in word 14/15, length goes to next block
            if (!pad_done_q) begin
              buf_q[wi]  <= 32'h8000_0000;
              pad_done_q <= 1'b1;
              spill_q    <= (idx_q >= 5'd14);
            end else if (!spill_q && idx_q == 5'd14) begin
              buf_q[wi] <= len64[63:32];
            end else if (!spill_q && idx_q == 5'd15) begin
              buf_q[wi]   <= len64[31:0];
              st_q        <= EMIT;
              blk_valid_q <= 1'b1;
              blk_last_q  <= 1'b1;
            end else begin
              buf_q[wi] <= '0;
            end
          end
        end
        EMIT: begin
          if (blk_valid_q && blk_ready) begin
            blk_valid_q <= 1'b0;
            idx_q       <= '0;
            blk_first_q <= blk_last_q;
            spill_q     <= 1'b0;
            if (blk_last_q) begin
              len_q      <= '0;
              pad_done_q <= 1'b0;
              padding_q  <= 1'b0;
              blk_last_q <= 1'b0;
              st_q       <= FILL;
              in_ready_q <= 1'b1;
            end else if (padding_q) begin
              st_q <= PAD;
            end else begin
              st_q       <= FILL;
              in_ready_q <= 1'b1;
            end
          end
        end
        default: st_q <= FILL;
      endcase
    end
  end

  for (genvar i = 0; i < 16; i++) begin : g_blk
    assign blk_data[511-32*i -: 32] = buf_q[i];
  end

  assign in_ready  = in_ready_q;
  assign blk_valid = blk_valid_q;
  assign blk_first = blk_first_q;
  assign blk_last  = blk_last_q;

endmodule

// File: tb/tb_sha256_msg_padder.sv
// tb_sha256_msg_padder: directed table, corner sequences and random messages
// checked against a byte-level FIPS 180-4 padding model.
module tb_sha256_msg_padder;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_last = 1'b0;
  logic [2:0]   in_bytes = '0;
  logic         in_ready;
  logic [511:0] blk_data;
  logic         blk_valid;
  logic         blk_first;
  logic         blk_last;
  logic         blk_ready = 1'b0;

  always #5 clk = ~clk;

  sha256_msg_padder #(.LEN_W(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_bytes  (in_bytes),
    .in_ready  (in_ready),
    .blk_data  (blk_data),
    .blk_valid (blk_valid),
    .blk_first (blk_first),
    .blk_last  (blk_last),
    .blk_ready (blk_ready)
  );

  typedef struct {
    logic [511:0] d;
    logic         f;
    logic         l;
  } blk_t;

  typedef struct {
    int          n;
    bit          extra;
    int          nblk;
    logic [31:0] w15;
  } vec_t;

  int          ntot = 0;
  int          bad = 0;
  int          blk_cnt = 0;
  logic [31:0] last_w15 = '0;
  bit          mon_en = 1'b0;
  int          rdy_mode = 1;
  blk_t        exp_q[$];
  vec_t        tbl[11];

  task automatic chk(input string nm, input logic [511:0] got,
                     input logic [511:0] exp);
    ntot++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Reference: whole-message padding on a byte queue, then cut into blocks
  task automatic model(input byte unsigned m[$]);
    byte unsigned p[$];
    logic [63:0]  bits;
    int           nb;
    blk_t         e;
    p = m;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    bits = 64'(m.size()) * 64'd8;
    for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
    nb = p.size() / 64;
    for (int b = 0; b < nb; b++) begin
      e.d = '0;
      for (int j = 0; j < 64; j++) e.d[511-8*j -: 8] = p[64*b+j];
      e.f = (b == 0);
      e.l = (b == nb - 1);
      exp_q.push_back(e);
    end
  endtask

  always begin
    @(posedge clk);
    #2;
    case (rdy_mode)
      0:       blk_ready = ($urandom_range(0, 3) != 0);
      1:       blk_ready = 1'b1;
      default: blk_ready = 1'b0;
    endcase
  end

  logic         held = 1'b0;
  logic [511:0] held_d = '0;

  always @(negedge clk) begin
    blk_t e;
    if (mon_en) begin
      if (blk_valid === 1'b1)
        chk("no_overlap", 512'(in_ready), 512'(0));
      if (held && blk_valid === 1'b1)
        chk("hold_data", blk_data, held_d);
      if (blk_valid === 1'b1 && blk_ready) begin
        if (exp_q.size() == 0) begin
          ntot++;
          bad++;
          $display("FAIL unexpected_block got_w0=%0h exp=none",
                   blk_data[511:480]);
        end else begin
          e = exp_q.pop_front();
          chk("blk_data", blk_data, e.d);
          chk("blk_first", 512'(blk_first), 512'(e.f));
          chk("blk_last", 512'(blk_last), 512'(e.l));
        end
        blk_cnt++;
        if (blk_last) last_w15 = blk_data[31:0];
        held = 1'b0;
      end else if (blk_valid === 1'b1) begin
        held   = 1'b1;
        held_d = blk_data;
      end else begin
        held = 1'b0;
      end
    end
  end

  task automatic send_word(input logic [31:0] d, input logic l,
                           input logic [2:0] b);
    int t;
    repeat ($urandom_range(0, 1)) begin
      @(posedge clk);
      #1;
    end
    in_data  = d;
    in_last  = l;
    in_bytes = b;
    in_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (in_ready !== 1'b1) begin
      ntot++;
      bad++;
      $display("FAIL in_ready_timeout got=0 exp=1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      ntot++;
      bad++;
      $display("FAIL drain_timeout got=%0d exp=0 blocks left", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_msg(input byte unsigned m[$], input bit extra);
    int          n;
    int          nw;
    int          k;
    bit          xe;
    logic        lw;
    logic [31:0] d;
    logic [2:0]  bb;
    model(m);
    n  = m.size();
    nw = (n + 3) / 4;
    xe = extra && n > 0 && (n % 4 == 0);
    if (n == 0) send_word($urandom, 1'b1, 3'd0);
    for (int w = 0; w < nw; w++) begin
      d = $urandom;
      k = n - 4 * w;
      if (k > 4) k = 4;
      for (int b = 0; b < k; b++) d[31-8*b -: 8] = m[4*w+b];
      lw = (w == nw - 1) && !xe;
      if (!lw) bb = 3'($urandom_range(0, 7));
      else if (k == 4) bb = 3'($urandom_range(4, 7));
      else bb = 3'(k);
      send_word(d, lw, bb);
    end
    if (xe) send_word($urandom, 1'b1, 3'd0);
    wait_drain();
  endtask

  function automatic void mk_msg(output byte unsigned m[$], input int n);
    m.delete();
    for (int i = 0; i < n; i++) m.push_back(8'(i * 7 + 1));
  endfunction

  function automatic void mk_abc(output byte unsigned m[$]);
    m.delete();
    m.push_back(8'h61);
    m.push_back(8'h62);
    m.push_back(8'h63);
  endfunction

  initial begin
    #600000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    byte unsigned m[$];
    int           n;
    int           c0;
    logic [511:0] h;

    tbl[0]  = '{0,   1'b0, 1, 32'd0};
    tbl[1]  = '{3,   1'b0, 1, 32'd24};
    tbl[2]  = '{55,  1'b0, 1, 32'd440};
    tbl[3]  = '{56,  1'b0, 2, 32'd448};
    tbl[4]  = '{60,  1'b0, 2, 32'd480};
    tbl[5]  = '{63,  1'b0, 2, 32'd504};
    tbl[6]  = '{64,  1'b0, 2, 32'd512};
    tbl[7]  = '{64,  1'b1, 2, 32'd512};
    tbl[8]  = '{8,   1'b1, 1, 32'd64};
    tbl[9]  = '{119, 1'b0, 2, 32'd952};
    tbl[10] = '{120, 1'b0, 3, 32'd960};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 512'(in_ready), 512'(0));
    chk("rst_blk_valid", 512'(blk_valid), 512'(0));
    chk("rst_blk_first", 512'(blk_first), 512'(1));
    chk("rst_blk_last", 512'(blk_last), 512'(0));
    chk("rst_blk_data", blk_data, 512'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_after_rst", 512'(in_ready), 512'(1));
    mon_en = 1'b1;

    // "abc" latency: 15 cycles from input transfer to blk_valid
    rdy_mode = 1;
    mk_abc(m);
    model(m);
    send_word(32'h6162_6300, 1'b1, 3'd3);
    n = 0;
    while (blk_valid !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("abc_latency", 512'(n), 512'(15));
    chk("abc_w0", 512'(blk_data[511:480]), 512'(32'h6162_6380));
    chk("abc_w15", 512'(blk_data[31:0]), 512'(32'h18));
    chk("abc_first", 512'(blk_first), 512'(1));
    chk("abc_last", 512'(blk_last), 512'(1));
    wait_drain();

    rdy_mode = 0;
    for (int i = 0; i < 11; i++) begin
      if (tbl[i].n == 3) mk_abc(m);
      else mk_msg(m, tbl[i].n);
      c0 = blk_cnt;
      run_msg(m, tbl[i].extra);
      chk("tbl_nblk", 512'(blk_cnt - c0), 512'(tbl[i].nblk));
      chk("tbl_len", 512'(last_w15), 512'(tbl[i].w15));
    end

    // backpressure on "abc", then a second message back to back
    rdy_mode = 2;
    mk_abc(m);
    model(m);
    send_word(32'h6162_6300, 1'b1, 3'd3);
    n = 0;
    while (blk_valid !== 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("bp_valid_rise", 512'(blk_valid), 512'(1));
    h = blk_data;
    repeat (10) begin
      @(posedge clk);
      #1;
      chk("bp_valid_held", 512'(blk_valid), 512'(1));
      chk("bp_in_ready", 512'(in_ready), 512'(0));
      chk("bp_data_held", blk_data, h);
    end
    rdy_mode = 1;
    @(posedge clk);
    #1;
    chk("bp_release", 512'(blk_valid), 512'(0));
    rdy_mode = 0;
    mk_msg(m, 13);
    c0 = blk_cnt;
    run_msg(m, 1'b0);
    chk("bp_next_nblk", 512'(blk_cnt - c0), 512'(1));
    chk("bp_next_len", 512'(last_w15), 512'(32'd104));

    // reset during PAD of a 56-byte message drops it entirely
    rdy_mode = 1;
    for (int w = 0; w < 14; w++)
      send_word(32'hA5A5_0000 | 32'(w), w == 13, 3'd4);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid_rst_valid", 512'(blk_valid), 512'(0));
    chk("mid_rst_first", 512'(blk_first), 512'(1));
    chk("mid_rst_last", 512'(blk_last), 512'(0));
    chk("mid_rst_data", blk_data, 512'(0));
    chk("mid_rst_ready", 512'(in_ready), 512'(0));
    repeat (20) begin
      @(posedge clk);
      #1;
    end
    chk("mid_rst_quiet", 512'(blk_valid), 512'(0));
    mk_abc(m);
    c0 = blk_cnt;
    run_msg(m, 1'b0);
    chk("post_rst_nblk", 512'(blk_cnt - c0), 512'(1));
    chk("post_rst_len", 512'(last_w15), 512'(32'd24));

    rdy_mode = 0;
    for (int r = 0; r < 40; r++) begin
      n = $urandom_range(0, 140);
      m.delete();
      for (int i = 0; i < n; i++) m.push_back(8'($urandom));
      c0 = blk_cnt;
      run_msg(m, 1'($urandom_range(0, 1)));
      chk("rnd_nblk", 512'(blk_cnt - c0), 512'((n + 9 + 63) / 64));
      chk("rnd_len", 512'(last_w15), 512'(32'(n * 8)));
    end

    $display("test done: total=%0d bad=%0d", ntot, bad);
    $finish;
  end

endmodule
